layer_sequencer: RTL and testbench
==================================

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 The block SHALL have parameter N_IN, default 784, meaning inputs per neuron (≥2).
REQ-002 The block SHALL have parameter N_NEURON, default 200, meaning neurons in the layer (≥1).
REQ-003 The block SHALL have parameter RELU_EN, default 1, meaning 1 applies ReLU to outputs and 0 passes them through (output layer).
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, meaning the reset, asynchronous and active-low.
REQ-006 The block SHALL have port start, input, 1, meaning a pulse that begins one full layer pass.
REQ-007 The block SHALL have port busy, output, 1, meaning a pass is in progress.
REQ-008 The block SHALL have port done, output, 1, meaning a one-cycle pulse when the pass completes.
REQ-009 The block SHALL have port in_addr, output, clog2(N_IN), meaning the input-vector read index.
REQ-010 The block SHALL have port in_data, input, 16, meaning the input value, signed Q8.8, valid one cycle after in_addr.
REQ-011 The block SHALL have port w_addr, output, clog2(N_IN*N_NEURON), meaning the weight-regfile address.
REQ-012 The block SHALL have port w_data, input, 16, meaning the weight, signed Q8.8, valid one cycle after w_addr.
REQ-013 The block SHALL have port b_addr, output, clog2(N_NEURON), meaning the bias-regfile address.
REQ-014 The block SHALL have port b_data, input, 16, meaning the bias, signed Q8.8, valid one cycle after b_addr.
REQ-015 The block SHALL have port out_valid, output, 1, meaning out_data/out_addr hold a finished neuron result.
REQ-016 The block SHALL have port out_ready, input, 1, meaning the sink accepts the result when out_valid and out_ready are both high.
REQ-017 The block SHALL have port out_addr, output, clog2(N_NEURON), meaning the neuron index of the result.
REQ-018 The block SHALL have port out_data, output, 16, meaning the result, signed Q8.8.

Function
REQ-019 The FSM SHALL have states IDLE, MAC, DRAIN, BIAS, OUT; busy is high in every state except IDLE.
REQ-020 In IDLE, start=1 SHALL clear the accumulator, set neuron n=0 and index i=0, and move to MAC; start outside IDLE SHALL be ignored.
REQ-021 In MAC, each cycle SHALL drive in_addr=i and w_addr=n*N_IN+i, then increment i; after i=N_IN-1 the FSM goes to DRAIN.
REQ-022 A one-cycle-delayed valid flag SHALL add in_data*w_data to the accumulator in the cycle after each address issue; no product is added without its flag.
REQ-023 In DRAIN, the block SHALL accumulate the final product and drive b_addr=n.
REQ-024 In BIAS, the block SHALL add b_data, sign-extended and shifted left 8, to the accumulator, then go to OUT.
REQ-025 The product SHALL be the exact 32-bit signed Q16.16 value; the accumulator SHALL be 42-bit signed Q26.16 and never wraps.
REQ-026 The result SHALL be the accumulator arithmetic-shifted right 8 (floor), saturated to [-32768, 32767], then set to 0 if negative when RELU_EN=1.
REQ-027 In OUT, out_valid SHALL be high with out_addr=n, and out_data SHALL stay stable until the out_valid&&out_ready handshake.
REQ-028 On handshake with n<N_NEURON-1, the block SHALL increment n, set i=0, clear the accumulator, and go to MAC in the next cycle.
REQ-029 On handshake with n=N_NEURON-1, the block SHALL pulse done for one cycle and go to IDLE.
REQ-030 Per-neuron latency from entering MAC to out_valid rising SHALL be N_IN+2 cycles with out_ready held high.
REQ-031 Address outputs SHALL be registered and SHALL hold their last value in IDLE and OUT.

Reset
REQ-032 While rst_n is low, the block SHALL force state IDLE and zero every output, the accumulator, n, i and the valid flag.
REQ-033 Reset asserted mid-pass SHALL abort the pass with no done pulse; a new start is required afterwards.

Verification
REQ-034 The bench SHALL run N_IN=4, N_NEURON=2 with all inputs 1.0 (0x0100), all weights 0.5 (0x0080) and biases 0.25 (0x0040) -> outputs 0x0240 at out_addr 0 then 1, then a single done pulse.
REQ-035 The bench SHALL use weights -2.0 with RELU_EN=1 -> out_data 0x0000; the same case with RELU_EN=0 -> 0xF840.
REQ-036 The bench SHALL use N_IN=784 with inputs and weights 0x7FFF -> out_data saturates to 0x7FFF.
REQ-037 The bench SHALL hold out_ready low for 5 cycles -> out_valid and out_data stay stable and the next neuron does not start.
REQ-038 The bench SHALL pulse start while busy -> no effect; the bench SHALL assert rst_n low during MAC -> outputs zero at once, busy=0, and no done.
REQ-039 The bench SHALL check the w_addr sequence 0,1,2,3 then 4,5,6,7 and the cycle count from start to first out_valid equal to N_IN+3.

Source files
------------

// File: rtl/layer_sequencer.sv
// layer_sequencer: walks one fully-connected layer neuron by neuron.
// For each neuron it streams N_IN input/weight pairs through a single
// multiply-accumulate, adds the bias, rounds down to Q8.8 with saturation
// (optional ReLU) and presents the result on a valid/ready output.
// Input, weight and bias memories are synchronous: data arrives one cycle
// after the address.
module layer_sequencer #(
   parameter int N_IN     = 784,
   parameter int N_NEURON = 200,
   parameter int RELU_EN  = 1
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 start,
   output logic                                 busy,
   output logic                                 done,
   output logic [$clog2(N_IN)-1:0]              in_addr,
   input  logic [15:0]                          in_data,
   output logic [$clog2(N_IN*N_NEURON)-1:0]     w_addr,
   input  logic [15:0]                          w_data,
   output logic [((N_NEURON > 1) ? $clog2(N_NEURON) : 1)-1:0] b_addr,
   input  logic [15:0]                          b_data,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [((N_NEURON > 1) ? $clog2(N_NEURON) : 1)-1:0] out_addr,
   output logic [15:0]                          out_data
);

   localparam int IW = $clog2(N_IN);
   localparam int WW = $clog2(N_IN * N_NEURON);
   localparam int NW = (N_NEURON > 1) ? $clog2(N_NEURON) : 1;
   localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);
   localparam logic [NW-1:0] N_LAST = NW'(N_NEURON - 1);

   typedef enum logic [2:0] {IDLE, MAC, DRAIN, BIAS, OUT} state_t;

   state_t               state_q, state_d;
   logic [IW-1:0]        i_q, i_d;
   logic [NW-1:0]        n_q, n_d;
   logic                 vld_q, vld_d;
   logic signed [41:0]   acc_q, acc_d;
   logic [IW-1:0]        in_addr_q, in_addr_d;
   logic [WW-1:0]        w_addr_q, w_addr_d;
   logic [NW-1:0]        b_addr_q, b_addr_d;
   logic                 out_valid_q, out_valid_d;
   logic [NW-1:0]        out_addr_q, out_addr_d;
   logic [15:0]          out_data_q, out_data_d;
   logic                 done_q, done_d;
   logic                 busy_q, busy_d;

   logic signed [31:0]   prod_s;
   logic signed [41:0]   prod_ext_s;
   logic signed [41:0]   bias_ext_s;

   // Q26.16 accumulator -> Q8.8 result: floor shift, saturate, optional ReLU.
   function automatic logic [15:0] sat_relu(input logic signed [41:0] acc);
      logic signed [41:0] sh;
      logic [15:0]        r;
      sh = acc >>> 8;
      if (sh > 42'sd32767) begin
         r = 16'h7FFF;
      end else if (sh < -42'sd32768) begin
         r = 16'h8000;
      end else begin
         r = sh[15:0];
      end
      if ((RELU_EN != 0) && r[15]) begin
         r = 16'h0000;
      end else begin
         r = r;
      end
      return r;
   endfunction

   // Exact Q16.16 product; bias promoted from Q8.8 to Q16.16 alignment.
   assign prod_s     = $signed(in_data) * $signed(w_data);
   assign prod_ext_s = {{10{prod_s[31]}}, prod_s};
   assign bias_ext_s = {{18{b_data[15]}}, b_data, 8'h00};

   // Next-state and next-output logic of the sequencer FSM.
   always_comb begin
      state_d     = state_q;
      i_d         = i_q;
      n_d         = n_q;
      vld_d       = 1'b0;
      in_addr_d   = in_addr_q;
      w_addr_d    = w_addr_q;
      b_addr_d    = b_addr_q;
      out_valid_d = out_valid_q;
      out_addr_d  = out_addr_q;
      out_data_d  = out_data_q;
      done_d      = 1'b0;
      // A product is only accumulated when its address was issued last cycle.
      if (vld_q) begin
         acc_d = acc_q + prod_ext_s;
      end else begin
         acc_d = acc_q;
      end
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = MAC;
               i_d       = {IW{1'b0}};
               n_d       = {NW{1'b0}};
               acc_d     = 42'sd0;
               in_addr_d = {IW{1'b0}};
               w_addr_d  = {WW{1'b0}};
            end else begin
               state_d = IDLE;
            end
         end
         MAC: begin
            vld_d = 1'b1;
            if (i_q == I_LAST) begin
               state_d  = DRAIN;
               b_addr_d = n_q;
            end else begin
               i_d       = i_q + IW'(1);
               in_addr_d = i_q + IW'(1);
               w_addr_d  = w_addr_q + WW'(1);
            end
         end
         DRAIN: begin
            state_d = BIAS;
         end
         BIAS: begin
            acc_d       = acc_q + bias_ext_s;
            out_data_d  = sat_relu(acc_d);
            out_valid_d = 1'b1;
            out_addr_d  = n_q;
            state_d     = OUT;
         end
         OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               if (n_q == N_LAST) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  n_d       = n_q + NW'(1);
                  i_d       = {IW{1'b0}};
                  acc_d     = 42'sd0;
                  in_addr_d = {IW{1'b0}};
                  // Weight rows are contiguous, so the next row starts one past the last.
                  w_addr_d  = w_addr_q + WW'(1);
                  state_d   = MAC;
               end
            end else begin
               state_d = OUT;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and datapath registers; reset clears everything and aborts a pass.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         i_q         <= {IW{1'b0}};
         n_q         <= {NW{1'b0}};
         vld_q       <= 1'b0;
         acc_q       <= 42'sd0;
         in_addr_q   <= {IW{1'b0}};
         w_addr_q    <= {WW{1'b0}};
         b_addr_q    <= {NW{1'b0}};
         out_valid_q <= 1'b0;
         out_addr_q  <= {NW{1'b0}};
         out_data_q  <= 16'h0000;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         i_q         <= i_d;
         n_q         <= n_d;
         vld_q       <= vld_d;
         acc_q       <= acc_d;
         in_addr_q   <= in_addr_d;
         w_addr_q    <= w_addr_d;
         b_addr_q    <= b_addr_d;
         out_valid_q <= out_valid_d;
         out_addr_q  <= out_addr_d;
         out_data_q  <= out_data_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign in_addr   = in_addr_q;
   assign w_addr    = w_addr_q;
   assign b_addr    = b_addr_q;
   assign out_valid = out_valid_q;
   assign out_addr  = out_addr_q;
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Testbench for layer_sequencer: two 4x2 instances (ReLU on/off) run in
// lockstep on shared memories, plus a 784-input instance for saturation.
module tb_layer_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   // Shared stimulus memories for the 4x2 pair.
   logic [15:0] in_mem [4];
   logic [15:0] w_mem  [8];
   logic [15:0] b_mem  [2];

   logic        start_a, ready_a;
   logic        busy0, done0, ov0, busy1, done1, ov1;
   logic [1:0]  ia0, ia1;
   logic [2:0]  wa0, wa1;
   logic [0:0]  ba0, ba1, oa0, oa1;
   logic [15:0] id0, wd0, bd0, od0, id1, wd1, bd1, od1;

   logic        start2, ready2, busy2, done2, ov2;
   logic [9:0]  ia2, wa2;
   logic [0:0]  ba2, oa2;
   logic [15:0] id2, wd2, bd2, od2;

   layer_sequencer #(.N_IN(4), .N_NEURON(2), .RELU_EN(1)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy0), .done(done0),
      .in_addr(ia0), .in_data(id0), .w_addr(wa0), .w_data(wd0),
      .b_addr(ba0), .b_data(bd0), .out_valid(ov0), .out_ready(ready_a),
      .out_addr(oa0), .out_data(od0));

   layer_sequencer #(.N_IN(4), .N_NEURON(2), .RELU_EN(0)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy1), .done(done1),
      .in_addr(ia1), .in_data(id1), .w_addr(wa1), .w_data(wd1),
      .b_addr(ba1), .b_data(bd1), .out_valid(ov1), .out_ready(ready_a),
      .out_addr(oa1), .out_data(od1));

   layer_sequencer #(.N_IN(784), .N_NEURON(1), .RELU_EN(1)) u2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
      .in_addr(ia2), .in_data(id2), .w_addr(wa2), .w_data(wd2),
      .b_addr(ba2), .b_data(bd2), .out_valid(ov2), .out_ready(ready2),
      .out_addr(oa2), .out_data(od2));

   // Synchronous-read memories: data one cycle after the address.
   always @(posedge clk) begin
      id0 <= in_mem[ia0];
      wd0 <= w_mem[wa0];
      bd0 <= b_mem[ba0];
      id1 <= in_mem[ia1];
      wd1 <= w_mem[wa1];
      bd1 <= b_mem[ba1];
      id2 <= (ia2 < 10'd784) ? 16'h7FFF : 16'h0000;
      wd2 <= (wa2 < 10'd784) ? 16'h7FFF : 16'h0000;
      bd2 <= {15'd0, ba2};
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: real dot product + bias, floor to Q8.8, saturate, ReLU.
   function automatic logic [15:0] model(input int n, input bit relu);
      longint acc;
      longint sh;
      logic [15:0] r;
      acc = 0;
      for (int k = 0; k < 4; k++)
         acc += longint'($signed(in_mem[k])) * longint'($signed(w_mem[n*4+k]));
      acc += longint'($signed(b_mem[n])) * 256;
      sh = acc >>> 8;
      if (sh > 32767) r = 16'h7FFF;
      else if (sh < -32768) r = 16'h8000;
      else r = sh[15:0];
      if (relu && r[15]) r = 16'h0000;
      return r;
   endfunction

   function automatic logic [15:0] rnd16();
      if ($urandom_range(0, 1) == 0) return 16'($urandom);
      else return 16'($urandom_range(0, 1023) - 512);
   endfunction

   // Wait for out_valid, checking address sequence and latency on the way.
   task automatic wait_pair(input int n, input bit glitch);
      int cnt;
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
         if (cnt <= 4) begin
            chk("w_addr_seq", wa0, n*4 + cnt - 1);
            chk("in_addr_seq", ia0, cnt - 1);
         end
         if (glitch && cnt == 2) start_a = 1'b1;
         else start_a = 1'b0;
      end while (!ov0 && cnt < 50);
      chk("latency_to_valid", cnt, 7);
      chk("u1_valid", ov1, 1);
   endtask

   task automatic run_pair(input bit glitch, input int stall_n);
      logic [15:0] e0, e1;
      start_a = 1'b1;
      for (int n = 0; n < 2; n++) begin
         wait_pair(n, glitch && (n == 0));
         e0 = model(n, 1'b1);
         e1 = model(n, 1'b0);
         chk("out_addr", oa0, n);
         chk("out_data_relu", od0, e0);
         chk("out_addr_norelu", oa1, n);
         chk("out_data_norelu", od1, e1);
         if (stall_n == n) begin
            ready_a = 1'b0;
            repeat (5) begin
               @(negedge clk);
               chk("stall_valid", ov0, 1);
               chk("stall_data", od0, e0);
               chk("stall_w_addr", wa0, n*4 + 3);
               chk("stall_busy", busy0, 1);
            end
            ready_a = 1'b1;
         end
      end
      @(negedge clk);
      chk("done_pulse", done0, 1);
      chk("done_pulse_u1", done1, 1);
      chk("busy_after_done", busy0, 0);
      chk("valid_after_done", ov0, 0);
      @(negedge clk);
      chk("done_single", done0, 0);
   endtask

   initial begin
      int cnt;
      bit saw_done;
      rst_n = 1'b0; start_a = 1'b0; ready_a = 1'b1; start2 = 1'b0; ready2 = 1'b1;
      for (int k = 0; k < 4; k++) in_mem[k] = 16'h0100;
      for (int k = 0; k < 8; k++) w_mem[k] = 16'h0080;
      for (int k = 0; k < 2; k++) b_mem[k] = 16'h0040;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy0, 0);
      chk("rst_done", done0, 0);
      chk("rst_valid", ov0, 0);
      chk("rst_data", od0, 0);
      chk("rst_w_addr", wa0, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic pass with a start pulse injected mid-pass.
      run_pair(1'b1, -1);
      chk("basic_result", od0, 16'h0240);

      // Negative weights, with a 5-cycle output stall on neuron 0.
      for (int k = 0; k < 8; k++) w_mem[k] = 16'hFE00;
      run_pair(1'b0, 0);
      chk("neg_relu", od0, 16'h0000);
      chk("neg_norelu", od1, 16'hF840);

      // Large layer saturation.
      start2 = 1'b1;
      cnt = 0;
      do begin
         @(negedge clk);
         start2 = 1'b0;
         cnt++;
      end while (!ov2 && cnt < 1000);
      chk("sat_latency", cnt, 787);
      chk("sat_data", od2, 16'h7FFF);
      chk("sat_addr", oa2, 0);
      @(negedge clk);
      chk("sat_done", done2, 1);

      // Randomized passes against the reference model.
      for (int t = 0; t < 6; t++) begin
         for (int k = 0; k < 4; k++) in_mem[k] = rnd16();
         for (int k = 0; k < 8; k++) w_mem[k] = rnd16();
         for (int k = 0; k < 2; k++) b_mem[k] = rnd16();
         run_pair(1'b0, (t == 2) ? 1 : -1);
      end

      // Reset during MAC aborts the pass.
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", busy0, 0);
      chk("abort_w_addr", wa0, 0);
      chk("abort_in_addr", ia0, 0);
      chk("abort_valid", ov0, 0);
      chk("abort_data", od0, 0);
      chk("abort_data_u1", od1, 0);
      chk("abort_done", done0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      saw_done = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (done0 || busy0 || ov0) saw_done = 1'b1;
      end
      chk("abort_stays_idle", saw_done, 0);

      // A fresh start works after the abort.
      for (int k = 0; k < 4; k++) in_mem[k] = rnd16();
      for (int k = 0; k < 8; k++) w_mem[k] = rnd16();
      for (int k = 0; k < 2; k++) b_mem[k] = rnd16();
      run_pair(1'b0, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
